control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microstep controller for the 8-bit computer. It is the block that sequences the shared 8-bit bus registers: PC, MAR, RAM, IR, A, B, ALU and OUT.
- Runs a fetch/execute cycle on a 3-bit step counter (T0..T4) and decodes the IR opcode into one-hot load/enable strobes each cycle.
- Register load strobes it drives take effect on the next clk edge.

Parameters:
OPCODE_W, 4, width of opcode field (IR[7:4])
STEP_W, 3, width of microstep counter (steps T0..T4 used)

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high; clears step and halted
run  in  1  1 = advance; 0 = pause (step frozen, strobes 0)
opcode  in  4  IR upper nibble; valid from T2 onward
flag_carry  in  1  registered ALU carry flag
flag_zero  in  1  registered ALU zero flag
pc_out, pc_inc, pc_load  out  1 each  program counter controls
mar_load  out  1  memory address register load
ram_out, ram_load  out  1 each  RAM bus drive / write
ir_load, ir_out  out  1 each  IR load / drive low nibble onto bus
a_load, a_out, b_load  out  1 each  register controls
alu_out, alu_sub, flags_load  out  1 each  ALU drive, subtract select, flag capture
out_load  out  1  output register load
halted  out  1  registered; 1 after HLT until reset
step  out  3  current microstep (debug)

Behaviour:
- Reset: step=T0 and halted=0 at the next edge. While reset=1, all strobes are forced 0.
- Strobes are combinational from (step, opcode, flags). All strobes are gated 0 when reset=1, halted=1 or run=0.
- Fetch, all opcodes:
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
- Execute, T2+ (signals listed per step; "last" means the next step is T0):
  - 0x0 NOP: T2 none (last).
  - 0x1 LDA: T2 ir_out, mar_load; T3 ram_out, a_load (last).
  - 0x2 ADD: T2 ir_out, mar_load; T3 ram_out, b_load; T4 alu_out, a_load, flags_load (last).
  - 0x3 SUB: as ADD, with alu_sub=1 in T4 only.
  - 0x4 STA: T2 ir_out, mar_load; T3 a_out, ram_load (last).
  - 0x5 LDI: T2 ir_out, a_load (last).
  - 0x6 JMP: T2 ir_out, pc_load (last).
  - 0x7 JC: T2 ir_out, pc_load only if flag_carry=1. T2 is last either way.
  - 0x8 JZ: same as JC, using flag_zero.
  - 0xE OUT: T2 a_out, out_load (last).
  - 0xF HLT: T2 no strobes; halted<=1 at the edge.
  - 0x9–0xD: treated as NOP.
- Step counter:
  - Advances by 1 per edge when run=1 and not halted.
  - Goes to T0 after the last step of the current instruction.
  - Never exceeds T4; T4 always returns to T0.
- Halted: step frozen, all strobes 0. Only reset clears it; run has no effect.
- run drops mid-instruction: step holds and strobes are 0. On resume, execution continues from the same step.
- Reset mid-instruction: the instruction is aborted; the next cycle after reset deasserts is T0 fetch.
- Simultaneous reset and HLT at T2: reset wins (halted=0).
- Bus exclusivity: at most one *_out strobe is 1 in any cycle. The bench asserts this.

Decomposition:
- cpu_pkg:
  - opcode enum (NOP..HLT values above);
  - step enum T0..T4;
  - packed control_word_t struct with all strobe fields;
  - STEP_W and OPCODE_W constants.
- One sub-module: control_decode. It is purely combinational: (step, opcode, flag_carry, flag_zero) -> control_word_t plus a last_step bit.
- control_sequencer holds the step/halted registers and gating, and unpacks the struct to ports.

Test Plan:
- Reset then run=1, opcode=0x0: step sequence 0,1,2,0.
  - T0: pc_out=mar_load=1.
  - T1: ram_out=ir_load=pc_inc=1.
  - T2: all strobes 0.
- opcode=0x2 (ADD) then 0x3 (SUB):
  - 5-step cycle for each.
  - T4: alu_out=a_load=flags_load=1; alu_sub=0 for ADD, 1 for SUB.
  - Next cycle is T0.
- opcode=0x7 (JC), flag_carry=0 then 1: pc_load=0 then 1 in T2; ir_out=1 in both; returns to T0 after T2.
- opcode=0xF (HLT): halted=1 one edge after T2; step frozen at 2; strobes 0 for 20 cycles with run=1. Assert reset: halted=0, step=0.
- run=0 at ADD T3 for 3 cycles: step stays 3 and strobes 0. On run=1, T3 strobes ram_out=b_load=1, then T4.
- reset=1 during LDA T3: strobes 0 while reset high; after release, step=0 with T0 strobes.
- One-hot bus check: across all opcodes 0x0–0xF and both flag values, at most one *_out strobe is 1 per cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
// Shared types for the 8-bit computer's control path: opcodes, microsteps and
// the control word that drives every bus register strobe.
package cpu_pkg;

  localparam int OPCODE_W = 4;
  localparam int STEP_W   = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [STEP_W-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  // halt is not a bus strobe: it asks the sequencer to set its halted flag.
  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_load;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
    logic halt;
  } control_word_t;

endpackage

// File: rtl/control_decode.sv
`timescale 1ns/1ps
// Pure microcode decoder: maps (step, opcode, flags) to the control word for
// this cycle and says whether this step ends the instruction.
module control_decode
  import cpu_pkg::*;
(
  input  step_e                step,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 flag_carry,
  input  logic                 flag_zero,
  output control_word_t        cw,
  output logic                 last_step
);

  // Microcode table; any step/opcode pair not listed drives no strobes.
  always_comb begin
    cw        = '0;
    last_step = 1'b0;
    case (step)
      T0: begin
        cw.pc_out   = 1'b1;
        cw.mar_load = 1'b1;
      end
      T1: begin
        cw.ram_out = 1'b1;
        cw.ir_load = 1'b1;
        cw.pc_inc  = 1'b1;
      end
      T2: begin
        case (opcode_e'(opcode))
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw.ir_out   = 1'b1;
            cw.mar_load = 1'b1;
          end
          OP_LDI: begin
            cw.ir_out  = 1'b1;
            cw.a_load  = 1'b1;
            last_step  = 1'b1;
          end
          OP_JMP: begin
            cw.ir_out  = 1'b1;
            cw.pc_load = 1'b1;
            last_step  = 1'b1;
          end
          OP_JC: begin
            cw.ir_out  = 1'b1;
            cw.pc_load = flag_carry;
            last_step  = 1'b1;
          end
          OP_JZ: begin
            cw.ir_out  = 1'b1;
            cw.pc_load = flag_zero;
            last_step  = 1'b1;
          end
          OP_OUT: begin
            cw.a_out    = 1'b1;
            cw.out_load = 1'b1;
            last_step   = 1'b1;
          end
          OP_HLT: begin
            cw.halt   = 1'b1;
            last_step = 1'b1;
          end
          // NOP and the unassigned opcodes 0x9..0xD.
          default: last_step = 1'b1;
        endcase
      end
      T3: begin
        case (opcode_e'(opcode))
          OP_LDA: begin
            cw.ram_out = 1'b1;
            cw.a_load  = 1'b1;
            last_step  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw.ram_out = 1'b1;
            cw.b_load  = 1'b1;
          end
          OP_STA: begin
            cw.a_out    = 1'b1;
            cw.ram_load = 1'b1;
            last_step   = 1'b1;
          end
          // Only reachable if the opcode changed mid-instruction; bail to fetch.
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        last_step = 1'b1;
        if (opcode_e'(opcode) == OP_ADD || opcode_e'(opcode) == OP_SUB) begin
          cw.alu_out    = 1'b1;
          cw.a_load     = 1'b1;
          cw.flags_load = 1'b1;
          cw.alu_sub    = (opcode_e'(opcode) == OP_SUB);
        end
      end
      default: last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
`timescale 1ns/1ps
// Fetch/execute microstep sequencer. Holds the step counter and halted flag,
// gates the decoded control word and fans it out to the register strobes.
// run acts as an advance qualifier: with run=0 the step holds and no strobe
// fires, so an instruction resumes exactly where it paused.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_carry,
  input  logic                flag_zero,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ram_out,
  output logic                ram_load,
  output logic                ir_load,
  output logic                ir_out,
  output logic                a_load,
  output logic                a_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                alu_sub,
  output logic                flags_load,
  output logic                out_load,
  output logic                halted,
  output logic [STEP_W-1:0]   step
);

  step_e         step_q, step_d;
  logic          halted_q, halted_d;
  logic          active;
  logic          last_step;
  control_word_t cw_raw, cw;

  control_decode u_decode (
    .step       (step_q),
    .opcode     (opcode),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .cw         (cw_raw),
    .last_step  (last_step)
  );

  // Next step / halted and strobe gating.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    active   = run && !halted_q && !reset;
    cw       = active ? cw_raw : '0;
    if (run && !halted_q) begin
      if (cw_raw.halt) begin
        halted_d = 1'b1;
      end else if (last_step || step_q == T4) begin
        step_d = T0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  // State registers; reset has priority, including over a HLT at T2.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign pc_out     = cw.pc_out;
  assign pc_inc     = cw.pc_inc;
  assign pc_load    = cw.pc_load;
  assign mar_load   = cw.mar_load;
  assign ram_out    = cw.ram_out;
  assign ram_load   = cw.ram_load;
  assign ir_load    = cw.ir_load;
  assign ir_out     = cw.ir_out;
  assign a_load     = cw.a_load;
  assign a_out      = cw.a_out;
  assign b_load     = cw.b_load;
  assign alu_out    = cw.alu_out;
  assign alu_sub    = cw.alu_sub;
  assign flags_load = cw.flags_load;
  assign out_load   = cw.out_load;
  assign halted     = halted_q;
  assign step       = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
// Bench for control_sequencer: directed scenarios followed by random traffic,
// checked every cycle against an instruction-list reference model.
module tb_control_sequencer;

  // Strobe vector layout used by the bench (not the RTL struct).
  localparam logic [14:0] PCO  = 15'h4000;
  localparam logic [14:0] PCI  = 15'h2000;
  localparam logic [14:0] PCL  = 15'h1000;
  localparam logic [14:0] MARL = 15'h0800;
  localparam logic [14:0] RAMO = 15'h0400;
  localparam logic [14:0] RAML = 15'h0200;
  localparam logic [14:0] IRL  = 15'h0100;
  localparam logic [14:0] IRO  = 15'h0080;
  localparam logic [14:0] AL   = 15'h0040;
  localparam logic [14:0] AO   = 15'h0020;
  localparam logic [14:0] BL   = 15'h0010;
  localparam logic [14:0] ALUO = 15'h0008;
  localparam logic [14:0] SUB  = 15'h0004;
  localparam logic [14:0] FL   = 15'h0002;
  localparam logic [14:0] OUTL = 15'h0001;
  localparam logic [14:0] BUS_DRIVERS = PCO | RAMO | IRO | AO | ALUO;

  typedef logic [14:0] uq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       flag_carry = 1'b0;
  logic       flag_zero = 1'b0;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load;
  logic       ir_load, ir_out, a_load, a_out, b_load;
  logic       alu_out, alu_sub, flags_load, out_load, halted;
  logic [2:0] step;
  logic [14:0] obs;

  int checks = 0;
  int errors = 0;

  // Reference model state: index into the current instruction's microstep list.
  int m_step   = 0;
  bit m_halted = 1'b0;
  bit m_known  = 1'b0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .pc_out     (pc_out),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .mar_load   (mar_load),
    .ram_out    (ram_out),
    .ram_load   (ram_load),
    .ir_load    (ir_load),
    .ir_out     (ir_out),
    .a_load     (a_load),
    .a_out      (a_out),
    .b_load     (b_load),
    .alu_out    (alu_out),
    .alu_sub    (alu_sub),
    .flags_load (flags_load),
    .out_load   (out_load),
    .halted     (halted),
    .step       (step)
  );

  assign obs = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load,
                ir_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load};

  // Whole instruction as an ordered list of strobe sets, fetch included.
  function automatic uq_t ucode(input logic [3:0] op, input logic c, input logic z);
    uq_t l;
    l.push_back(PCO | MARL);
    l.push_back(RAMO | IRL | PCI);
    case (op)
      4'h1: begin l.push_back(IRO | MARL); l.push_back(RAMO | AL); end
      4'h2: begin l.push_back(IRO | MARL); l.push_back(RAMO | BL); l.push_back(ALUO | AL | FL); end
      4'h3: begin l.push_back(IRO | MARL); l.push_back(RAMO | BL); l.push_back(ALUO | AL | FL | SUB); end
      4'h4: begin l.push_back(IRO | MARL); l.push_back(AO | RAML); end
      4'h5: l.push_back(IRO | AL);
      4'h6: l.push_back(IRO | PCL);
      4'h7: l.push_back(IRO | (c ? PCL : 15'h0));
      4'h8: l.push_back(IRO | (z ? PCL : 15'h0));
      4'hE: l.push_back(AO | OUTL);
      default: l.push_back(15'h0);
    endcase
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    uq_t l;
    logic [14:0] exp_strobes;
    @(negedge clk);
    l = ucode(opcode, flag_carry, flag_zero);
    if (reset || m_halted || !run || !m_known) exp_strobes = 15'h0;
    else exp_strobes = l[m_step];
    chk("strobes", {17'h0, obs}, {17'h0, exp_strobes});
    chk("bus_exclusive", {31'h0, ($countones(obs & BUS_DRIVERS) <= 1)}, 32'h1);
    if (m_known) begin
      chk("step", {29'h0, step}, m_step);
      chk("halted", {31'h0, halted}, {31'h0, m_halted});
    end
    @(posedge clk);
    if (reset) begin
      m_step = 0; m_halted = 1'b0; m_known = 1'b1;
    end else if (m_known && !m_halted && run) begin
      if (opcode == 4'hF && m_step == 2) m_halted = 1'b1;
      else if (m_step == l.size() - 1) m_step = 0;
      else m_step = m_step + 1;
    end
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset with run low, then NOP.
    reset = 1'b1; run = 1'b0;
    cycles(2);
    reset = 1'b0; run = 1'b1; opcode = 4'h0;
    cycles(4);
    chk("nop_back_to_t1", {29'h0, step}, 32'd1);
    cycles(2);

    // ADD then SUB, five steps each.
    opcode = 4'h2; cycles(5);
    opcode = 4'h3; cycles(5);

    // JC with carry clear then set.
    opcode = 4'h7; flag_carry = 1'b0; cycles(3);
    flag_carry = 1'b1; cycles(3);
    flag_carry = 1'b0;

    // ADD paused at T3 for three cycles, then resumed.
    opcode = 4'h2; cycles(3);
    run = 1'b0; cycles(3);
    run = 1'b1; cycles(2);

    // LDA aborted by reset at T3.
    opcode = 4'h1; cycles(3);
    reset = 1'b1; cycles(2);
    reset = 1'b0; opcode = 4'h1; cycles(4);

    // Sweep all non-halt opcodes with every flag combination.
    for (int op = 0; op < 15; op++) begin
      for (int f = 0; f < 4; f++) begin
        opcode = 4'(op); flag_carry = f[0]; flag_zero = f[1];
        for (int k = 0; k < 6 && !(k > 0 && m_step == 0); k++) cycle();
      end
    end

    // Randomised traffic; opcode only changes between instructions.
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      run        = ($urandom_range(0, 3) != 0);
      flag_carry = 1'($urandom_range(0, 1));
      flag_zero  = 1'($urandom_range(0, 1));
      if (m_step == 0) opcode = 4'($urandom_range(0, 15));
      cycle();
    end

    // HLT: halts after T2, stays frozen with run high, only reset clears it.
    reset = 1'b1; run = 1'b1; cycle();
    reset = 1'b0; opcode = 4'hF; cycles(3);
    chk("hlt_halted", {31'h0, halted}, 32'h1);
    chk("hlt_step", {29'h0, step}, 32'd2);
    cycles(20);
    reset = 1'b1; cycle();
    reset = 1'b0; opcode = 4'h0;
    chk("hlt_cleared", {31'h0, halted}, 32'h0);
    chk("hlt_step_reset", {29'h0, step}, 32'd0);
    cycles(3);

    // Reset coinciding with HLT at T2: reset wins.
    opcode = 4'hF; cycles(2);
    reset = 1'b1; cycle();
    reset = 1'b0;
    chk("reset_beats_hlt", {31'h0, halted}, 32'h0);
    opcode = 4'h0; cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
